trade_z_engine: RTL and testbench

//  Parametrised successor to the fixed-width Z-score trader. Takes one (mean, mean-of-squares, price)

---
 rtl/trade_pkg.sv | 24 ++
 rtl/isqrt_seq.sv | 67 ++++++
 rtl/trade_z_engine.sv | 178 +++++++++++++++++
 tb/tb_trade_z_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/trade_pkg.sv
// Shared types and constants for the Z-score trading engine.
package trade_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQRT,
    CMP,
    HOLD
  } state_t;

  // Fraction bits of the Q4.4 Z threshold
  localparam int Q_FRAC = 4;

  // Widest DATA_W the decision record can carry
  localparam int MAX_DATA_W = 16;

  typedef struct packed {
    logic                  buy;
    logic                  sell;
    logic [MAX_DATA_W-1:0] stddev;
    logic                  var_clamp;
  } decision_t;

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: 2*DATA_W radicand -> DATA_W root.
// One root bit per cycle for DATA_W cycles after start; done pulses for one cycle
// on the edge that completes the last bit, and root holds until the next start.
module isqrt_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*DATA_W-1:0]   radicand,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     root
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REM_W = DATA_W + 4;

  logic [2*DATA_W-1:0] rad_q;
  logic [REM_W-1:0]    rem_q;
  logic [DATA_W-1:0]   root_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [REM_W-1:0]    rem_sh;
  logic [REM_W-1:0]    trial;
  logic [REM_W-1:0]    rem_sub;
  logic                bit_ok;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1
  always_comb begin
    rem_sh  = (rem_q << 2) | REM_W'(rad_q[2*DATA_W-1 -: 2]);
    trial   = (REM_W'(root_q) << 2) | REM_W'(1);
    bit_ok  = (rem_sh >= trial);
    rem_sub = rem_sh - trial;
  end

  // Iteration registers; the down-counter marks the remaining root bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rad_q  <= radicand;
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= CNT_W'(DATA_W);
      end else if (cnt_q != '0) begin
        rad_q  <= rad_q << 2;
        rem_q  <= bit_ok ? rem_sub : rem_sh;
        root_q <= {root_q[DATA_W-2:0], bit_ok};
        cnt_q  <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (cnt_q != '0);
  assign root = root_q;

endmodule

// File: rtl/trade_z_engine.sv
// Z-score mean-reversion trader: variance from (mean, mean-of-squares), sequential
// integer stddev, then a buy/sell decision against a Q4.4 Z threshold.
// Optional feature macro: TRADE_Z_COOLDOWN_EN (post-signal cooldown counter).
//
//  state | meaning
//  IDLE  | in_ready=1, waiting for a sample; capture + start root on accept
//  SQRT  | root running (DATA_W bit steps), leave when the root reports done
//  CMP   | one cycle: compare |price-mean|*16 against Z_THRESH*stddev
//  HOLD  | out_valid=1, decision held until out_ready
module trade_z_engine
  import trade_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter logic [7:0]  Z_THRESH = 8'h20,
  parameter int          COOLDOWN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   mean,
  input  logic [2*DATA_W-1:0] sqr_mean,
  input  logic [DATA_W-1:0]   price,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                buy_signal,
  output logic                sell_signal,
  output logic [DATA_W-1:0]   stddev,
  output logic                var_clamp
);

  localparam int CMP_W = DATA_W + 8;

  state_t state_q, state_d;

  logic                accept;
  logic [2*DATA_W-1:0] mean_sq;
  logic                clamp_d;
  logic [2*DATA_W-1:0] var_d;

  logic [DATA_W-1:0]   mean_q;
  logic [DATA_W-1:0]   price_q;
  logic                clamp_q;

  logic                sqrt_busy_unused;
  logic                sqrt_done;
  logic [DATA_W-1:0]   sqrt_root;

  logic signed [DATA_W:0] dev;
  logic [DATA_W:0]        mag;
  logic [CMP_W-1:0]       lhs;
  logic [CMP_W-1:0]       rhs;
  logic                   hit;
  logic                   cd_block;

  decision_t dec_d;
  decision_t dec_q;
  logic [MAX_DATA_W-1:0] stddev_full_unused;

  assign accept = (state_q == IDLE) && in_valid;

  // Variance of the incoming sample; a negative result means inconsistent inputs
  always_comb begin
    mean_sq = (2*DATA_W)'(mean) * (2*DATA_W)'(mean);
    clamp_d = (sqr_mean < mean_sq);
    var_d   = clamp_d ? '0 : (sqr_mean - mean_sq);
  end

  isqrt_seq #(.DATA_W(DATA_W)) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .radicand (var_d),
    .busy     (sqrt_busy_unused),
    .done     (sqrt_done),
    .root     (sqrt_root)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SQRT;
      end
      SQRT: begin
        if (sqrt_done) state_d = CMP;
      end
      CMP: begin
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Z-score compare, all in CMP_W bits so Z_THRESH*stddev cannot overflow
  always_comb begin
    dev   = $signed({1'b0, price_q}) - $signed({1'b0, mean_q});
    mag   = dev[DATA_W] ? (DATA_W+1)'(-dev) : (DATA_W+1)'(dev);
    lhs   = CMP_W'(mag) << Q_FRAC;
    rhs   = CMP_W'(Z_THRESH) * CMP_W'(sqrt_root);
    hit   = (sqrt_root != '0) && (lhs >= rhs);
    dec_d = '0;
    dec_d.buy       = hit && dev[DATA_W] && !cd_block;
    dec_d.sell      = hit && !dev[DATA_W] && (dev != '0) && !cd_block;
    dec_d.stddev    = MAX_DATA_W'(sqrt_root);
    dec_d.var_clamp = clamp_q;
  end

  // Sample capture on accept; decision register loads only on CMP -> HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mean_q  <= '0;
      price_q <= '0;
      clamp_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      if (accept) begin
        mean_q  <= mean;
        price_q <= price;
        clamp_q <= clamp_d;
      end
      if (state_q == CMP) begin
        dec_q <= dec_d;
      end
    end
  end

`ifdef TRADE_Z_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic [CD_W-1:0] cd_cnt_q;
  logic            cd_block_q;

  // Cooldown: the block flag is sampled before the decrement so COOLDOWN
  // samples are suppressed after a signalled decision is handed off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_cnt_q   <= '0;
      cd_block_q <= 1'b0;
    end else if (accept) begin
      cd_block_q <= (cd_cnt_q != '0);
      if (cd_cnt_q != '0) cd_cnt_q <= cd_cnt_q - CD_W'(1);
    end else if ((state_q == HOLD) && out_ready && (dec_q.buy || dec_q.sell)) begin
      cd_cnt_q <= CD_W'(COOLDOWN);
    end
  end

  assign cd_block = cd_block_q;
`else
  logic cooldown_unused;
  assign cooldown_unused = (COOLDOWN != 0);
  assign cd_block = 1'b0;
`endif

  assign buy_signal         = dec_q.buy;
  assign sell_signal        = dec_q.sell;
  assign stddev             = dec_q.stddev[DATA_W-1:0];
  assign var_clamp          = dec_q.var_clamp;
  assign stddev_full_unused = dec_q.stddev;

endmodule

// File: tb/tb_trade_z_engine.sv
// Bench for trade_z_engine: directed cases plus random samples against a
// plain-arithmetic reference model. Honours TRADE_Z_COOLDOWN_EN when defined.
module tb_trade_z_engine;

  localparam int         DATA_W = 8;
  localparam logic [7:0] ZT     = 8'h20;
  localparam int         CD     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_W-1:0]   mean = '0;
  logic [2*DATA_W-1:0] sqr_mean = '0;
  logic [DATA_W-1:0]   price = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                buy_signal;
  logic                sell_signal;
  logic [DATA_W-1:0]   stddev;
  logic                var_clamp;

  int total = 0;
  int bad   = 0;
  int cd_model = 0;
  logic last_buy;

  trade_z_engine #(.DATA_W(DATA_W), .Z_THRESH(ZT), .COOLDOWN(CD)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mean        (mean),
    .sqr_mean    (sqr_mean),
    .price       (price),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .buy_signal  (buy_signal),
    .sell_signal (sell_signal),
    .stddev      (stddev),
    .var_clamp   (var_clamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt_ref(input int v);
    int s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  // Drive one sample, wait for the decision, hold it for 'hold' cycles, hand off
  task automatic run_sample(input int m, input int sq, input int p, input int hold, input string tag);
    int mm, vr, s, dv, mg, lat;
    bit clamp, hit, act, eb, es, got;
    mm    = m * m;
    clamp = (sq < mm);
    vr    = clamp ? 0 : sq - mm;
    s     = isqrt_ref(vr);
    dv    = p - m;
    mg    = (dv < 0) ? -dv : dv;
    hit   = (s != 0) && (mg * 16 >= int'(ZT) * s);
    act   = 1'b0;
`ifdef TRADE_Z_COOLDOWN_EN
    act = (cd_model != 0);
    if (cd_model != 0) cd_model--;
`endif
    eb = hit && (dv < 0) && !act;
    es = hit && (dv > 0) && !act;

    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mean     = DATA_W'(m);
    sqr_mean = (2*DATA_W)'(sq);
    price    = DATA_W'(p);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mean     = DATA_W'($urandom);
    price    = DATA_W'($urandom);

    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    check({tag, "/latency"}, 32'(lat), 32'd10);
    check({tag, "/buy"},     32'(buy_signal),  32'(eb));
    check({tag, "/sell"},    32'(sell_signal), 32'(es));
    check({tag, "/stddev"},  32'(stddev),      32'(s));
    check({tag, "/clamp"},   32'(var_clamp),   32'(clamp));
    last_buy = buy_signal;

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      mean     = DATA_W'($urandom);
      sqr_mean = (2*DATA_W)'($urandom);
      price    = DATA_W'($urandom);
      @(posedge clk); #1;
      check({tag, "/hold_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "/hold_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_stable"}, 32'({buy_signal, sell_signal, var_clamp, stddev}),
            32'({eb, es, clamp, 8'(s)}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/handoff"}, 32'(out_valid), 32'd0);
`ifdef TRADE_Z_COOLDOWN_EN
    if (eb || es) cd_model = CD;
`endif
  endtask

  initial begin
    int m, sq, p, seen;

    // Reset state
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check("rst/in_ready",  32'(in_ready),    32'd1);
    check("rst/out_valid", 32'(out_valid),   32'd0);
    check("rst/buy",       32'(buy_signal),  32'd0);
    check("rst/sell",      32'(sell_signal), 32'd0);
    check("rst/stddev",    32'(stddev),      32'd0);
    check("rst/clamp",     32'(var_clamp),   32'd0);

    // Directed cases
    run_sample(100, 10100, 75, 0, "buy75");
    run_sample(100, 10100, 120, 0, "sell120");
    run_sample(100, 10100, 119, 0, "edge119");
    run_sample(50, 2000, 10, 0, "clamp");
    run_sample(100, 10100, 75, 20, "hold20");

    // Reset pulse in the middle of SQRT aborts the sample
    rst = 1'b1; #2 rst = 1'b0;
    cd_model = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    mean = 8'd100; sqr_mean = 16'd10100; price = 8'd75;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    cd_model = 0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort/no_valid", 32'(seen), 32'd0);
    check("abort/in_ready", 32'(in_ready), 32'd1);
    run_sample(100, 10100, 75, 0, "after_abort");

`ifdef TRADE_Z_COOLDOWN_EN
    rst = 1'b1; #2 rst = 1'b0;
    cd_model = 0;
    @(posedge clk); #1;
    run_sample(100, 10100, 75, 0, "cd0"); check("cd0/seq", 32'(last_buy), 32'd1);
    run_sample(100, 10100, 70, 0, "cd1"); check("cd1/seq", 32'(last_buy), 32'd0);
    run_sample(100, 10100, 60, 0, "cd2"); check("cd2/seq", 32'(last_buy), 32'd0);
    run_sample(100, 10100, 75, 0, "cd3"); check("cd3/seq", 32'(last_buy), 32'd1);
`endif

    // Random samples against the reference model
    for (int n = 0; n < 30; n++) begin
      m = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) sq = int'($urandom_range(0, 65535));
      else begin
        sq = m * m + int'($urandom_range(0, 3000));
        if (sq > 65535) sq = 65535;
      end
      if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, 255));
      else begin
        p = m + int'($urandom_range(0, 120)) - 60;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
      end
      run_sample(m, sq, p, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
